seq_divider: RTL and testbench

- Sequential restoring radix-2 divider; the responder side of the start/ready divide handshake that the averaging stage (10-sample sum ÷ 10) initiates.
- Accepts an unsigned dividend/divisor pair on a one-cycle start pulse and computes one quotient bit per clock.
- Returns a QW-bit saturated quotient plus the full remainder with a one-cycle ready pulse.
- Sits between the per-point sum logic and the packed ratio store.

---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring radix-2 divider with saturated quotient
module seq_divider #(
    parameter int DW = 20,
    parameter int QW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          ready,
    output logic          busy,
    output logic          div_zero,
    output logic          overflow
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    // dvd starts as the dividend and is shifted left each step; the vacated
    // LSBs collect quotient bits, so after DW steps it holds the full quotient.
    logic [DW-1:0] dvd;
    logic [DW-1:0] dsr;
    logic [DW-1:0] prem;
    logic [CW-1:0] cnt;
    logic          dz;

    logic [DW:0]   shifted;
    logic [DW-1:0] diff_lo;
    logic          take;
    logic          q_over;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // When the subtraction is kept the result is below the divisor, so the
    // low DW bits of the modular difference are the exact new remainder.
    always_comb begin
        shifted = {prem, dvd[DW-1]};
        take    = (shifted >= {1'b0, dsr});
        diff_lo = shifted[DW-1:0] - dsr;
        q_over  = |dvd[DW-1:QW];
    end

    // Control FSM and datapath; outputs registered when leaving FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        dvd  <= dividend;
                        dsr  <= divisor;
                        prem <= '0;
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            dz    <= 1'b1;
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            dz    <= 1'b0;
                            cnt   <= CW'(DW);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem <= take ? diff_lo : shifted[DW-1:0];
                    dvd  <= {dvd[DW-2:0], take};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= dvd;
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else begin
                        quotient  <= q_over ? '1 : dvd[QW-1:0];
                        remainder <= prem;
                        div_zero  <= 1'b0;
                        overflow  <= q_over;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] dividend;
    logic [19:0] divisor;
    logic [11:0] quotient;
    logic [19:0] remainder;
    logic        ready;
    logic        busy;
    logic        div_zero;
    logic        overflow;

    int n_cmp;
    int n_bad;

    seq_divider #(.DW(20), .QW(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (ready),
        .busy      (busy),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, saturated to 12 bits.
    function automatic void model(input int unsigned a, input int unsigned b,
                                  output int unsigned q, output int unsigned r,
                                  output bit ov, output bit dz, output int lat);
        if (b == 0) begin
            q = 32'hFFF; r = a; ov = 1'b0; dz = 1'b1; lat = 1;
        end else begin
            ov = (a / b) > 4095;
            q  = ov ? 32'hFFF : a / b;
            r  = a % b;
            dz = 1'b0;
            lat = 21;
        end
    endfunction

    // Issues a request at the current negedge and waits for ready (bounded).
    // lat counts edges after the start-sampling edge up to the one raising ready.
    task automatic run_div(input logic [19:0] a, input logic [19:0] b, input bit inject,
                           output int lat, output int busy_cycles, output bit timeout);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        lat         = 0;
        timeout     = 1'b0;
        busy_cycles = busy ? 1 : 0;
        forever begin
            if (inject && (lat == 5 || lat == 10)) begin
                dividend = 20'($urandom);
                divisor  = 20'($urandom_range(1, 50));
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (ready) break;
            if (busy) busy_cycles++;
            if (lat > 100) begin
                timeout = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({quotient, remainder, ready, busy, div_zero, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got q=%0d r=%0d rdy=%b busy=%b dz=%b ov=%b expected all 0",
                     quotient, remainder, ready, busy, div_zero, overflow);
        end
    endtask

    task automatic test_basic();
        int lat, bc; bit to;
        run_div(20'd100, 20'd10, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || lat != 21) begin n_bad++; $display("FAIL basic_latency got %0d expected 21 (timeout=%b)", lat, to); end
        n_cmp++;
        if (bc != 21) begin n_bad++; $display("FAIL basic_busy got %0d cycles expected 21", bc); end
        n_cmp++;
        if (quotient !== 12'd10 || remainder !== 20'd0 || overflow !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_result got q=%0d r=%0d ov=%b dz=%b busy=%b expected 10 0 0 0 0",
                     quotient, remainder, overflow, div_zero, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_width got ready=%b expected 0", ready); end
    endtask

    task automatic test_averaging();
        int lat, bc; bit to;
        run_div(20'd40950, 20'd10, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || quotient !== 12'd4095 || remainder !== 20'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL avg_full_scale got q=%0d r=%0d ov=%b expected 4095 0 0", quotient, remainder, overflow);
        end
        @(negedge clk);
        run_div(20'd12345, 20'd10, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || quotient !== 12'd1234 || remainder !== 20'd5) begin
            n_bad++;
            $display("FAIL avg_12345 got q=%0d r=%0d expected 1234 5", quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat, bc; bit to;
        run_div(20'd65535, 20'd10, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || quotient !== 12'hFFF || remainder !== 20'd5 || overflow !== 1'b1 || div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_65535 got q=%0d r=%0d ov=%b dz=%b expected 4095 5 1 0",
                     quotient, remainder, overflow, div_zero);
        end
        @(negedge clk);
        run_div(20'd20, 20'd3, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || quotient !== 12'd6 || remainder !== 20'd2 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear got q=%0d r=%0d ov=%b expected 6 2 0", quotient, remainder, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bc; bit to;
        run_div(20'd777, 20'd0, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || lat != 1) begin n_bad++; $display("FAIL dz_latency got %0d expected 1", lat); end
        n_cmp++;
        if (quotient !== 12'hFFF || remainder !== 20'd777 || div_zero !== 1'b1 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_result got q=%0d r=%0d dz=%b ov=%b expected 4095 777 1 0",
                     quotient, remainder, div_zero, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat, bc; bit to;
        run_div(20'd500, 20'd7, 1'b1, lat, bc, to);
        n_cmp++;
        if (to || lat != 21 || quotient !== 12'd71 || remainder !== 20'd3) begin
            n_bad++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d expected 21 71 3", lat, quotient, remainder);
        end
        // Do not wait: the next request is issued in the ready cycle itself.
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit to;
        time t1, t2;
        t1 = $time;
        run_div(20'd20, 20'd3, 1'b0, lat, bc, to);
        t2 = $time;
        n_cmp++;
        if (to || (t2 - t1) != 220) begin
            n_bad++;
            $display("FAIL b2b_spacing got %0d cycles expected 22", (t2 - t1) / 10);
        end
        n_cmp++;
        if (quotient !== 12'd6 || remainder !== 20'd2) begin
            n_bad++;
            $display("FAIL b2b_result got q=%0d r=%0d expected 6 2", quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit to; bit seen;
        dividend = 20'd1000; divisor = 20'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({quotient, remainder, ready, busy, div_zero, overflow} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got q=%0d r=%0d rdy=%b busy=%b dz=%b ov=%b expected all 0",
                     quotient, remainder, ready, busy, div_zero, overflow);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ready || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL midreset_no_ready got activity=1 expected 0"); end
        run_div(20'd9, 20'd4, 1'b0, lat, bc, to);
        n_cmp++;
        if (to || lat != 21 || quotient !== 12'd2 || remainder !== 20'd1) begin
            n_bad++;
            $display("FAIL midreset_after got lat=%0d q=%0d r=%0d expected 21 2 1", lat, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bc, elat; bit to, eov, edz;
        int unsigned a, b, eq, er;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 20'hFFFFF);
            case ($urandom_range(0, 7))
                0:       b = 0;
                1, 2, 3: b = $urandom_range(1, 300);
                default: b = $urandom_range(1, 20'hFFFFF);
            endcase
            model(a, b, eq, er, eov, edz, elat);
            run_div(20'(a), 20'(b), 1'b0, lat, bc, to);
            n_cmp++;
            if (to || lat != elat || quotient !== 12'(eq) || remainder !== 20'(er) ||
                overflow !== eov || div_zero !== edz) begin
                n_bad++;
                $display("FAIL random_%0d %0d/%0d got lat=%0d q=%0d r=%0d ov=%b dz=%b expected %0d %0d %0d %b %b",
                         i, a, b, lat, quotient, remainder, overflow, div_zero, elat, eq, er, eov, edz);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_averaging();
        test_saturation();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
